instr_prefetch: RTL

//  Byte prefetcher between the 256x8 program memory and the processor decoder.

---
 rtl/instr_prefetch_pkg.sv | 20 ++
 rtl/prefetch_fifo.sv | 44 ++++
 rtl/instr_prefetch.sv | 78 +++++++
 3 files changed

// File: rtl/instr_prefetch_pkg.sv
// Shared decode constants and the opcode-length function, used by both the
// prefetcher and the processor decoder.
package instr_prefetch_pkg;

  localparam logic [1:0] INSTR_SIZE_1 = 2'd1;
  localparam logic [1:0] INSTR_SIZE_2 = 2'd2;
  localparam logic [1:0] INSTR_SIZE_3 = 2'd3;

  // Instruction length in bytes from the opcode low nibble.
  function automatic logic [1:0] instr_size(input logic [3:0] nib);
    if (nib[3:1] == 3'b111) begin
      return INSTR_SIZE_1;
    end else if (nib[3:2] == 2'b01 || nib == 4'hD) begin
      return INSTR_SIZE_3;
    end else begin
      return INSTR_SIZE_2;
    end
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH x 8 circular byte buffer: one push per cycle, pop of 0-3 bytes,
// head..head+2 exposed combinationally. Flush empties it in one cycle.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic [1:0]    pop_cnt,
  output logic [7:0]    head0,
  output logic [7:0]    head1,
  output logic [7:0]    head2,
  output logic [CW-1:0] count
);

  logic [7:0]    buf_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      count  <= count + CW'(push) - CW'(pop_cnt);
    end
  end

  // Pointer arithmetic is PW bits wide, so the head window wraps mod DEPTH.
  assign head0 = buf_q[rd_ptr];
  assign head1 = buf_q[rd_ptr + PW'(1)];
  assign head2 = buf_q[rd_ptr + PW'(2)];

endmodule

// File: rtl/instr_prefetch.sv
// Sequential byte prefetcher feeding whole 1-3 byte instructions to the decoder;
// first instruction 2-4 cycles after restart, fetch stalls while FIFO+inflight is full.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_strobe,
  input  logic [7:0]            mem_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [23:0]           instr_bytes,
  output logic [1:0]            instr_size,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic                  inflight;
  logic [CW-1:0]         count;
  logic [7:0]            h0, h1, h2;
  logic [1:0]            head_size;
  logic                  strobe, push, pop, valid;

  assign head_size = instr_prefetch_pkg::instr_size(h0[3:0]);
  assign valid     = !reset && (count >= CW'(head_size));
  // Inflight byte reserves a slot so a returning read always has room.
  assign strobe    = !reset && !redirect && ((count + CW'(inflight)) < CW'(DEPTH));
  assign push      = inflight && !redirect;
  assign pop       = valid && instr_ready && !redirect;

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (mem_data),
    .pop_cnt   (pop ? head_size : 2'd0),
    .head0     (h0),
    .head1     (h1),
    .head2     (h2),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= '0;
      head_pc  <= '0;
      inflight <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      head_pc  <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= strobe;
      if (strobe) fetch_pc <= fetch_pc + 1'b1;
      if (pop)    head_pc  <= head_pc + ADDR_WIDTH'(head_size);
    end
  end

  assign mem_strobe  = strobe;
  assign mem_addr    = reset ? '0 : fetch_pc;
  assign instr_valid = valid;
  assign instr_size  = head_size;
  assign instr_pc    = reset ? '0 : head_pc;
  assign instr_bytes = valid ? {h0,
                                (head_size != INSTR_SIZE_1) ? h1 : 8'h00,
                                (head_size == INSTR_SIZE_3) ? h2 : 8'h00} : 24'h0;

endmodule
